// File: rtl/hazard_sequencer.sv
// Fetch/decode hazard sequencer: load stalls, branch-resolution waits, memory freeze, branch timeout.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_sequencer #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned BRANCH_WAIT_MAX   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_bubble,
    input  logic        branch_bubble,
    input  logic        branch_resolved,
    input  logic        branch_taken,
    input  logic        mem_wait,
    output logic        fetch_stall,
    output logic        decode_bubble,
    output logic        pc_redirect,
    output logic        fetch_flush,
    output logic        pipe_freeze,
    output logic        hazard_error,
    output logic [0:15] stall_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        BWAIT  = 2'd2
    } state_t;

    localparam logic [0:3] LOAD_INIT = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
    localparam logic [0:3] BWAIT_MAX = 4'(BRANCH_WAIT_MAX);

    state_t     state, state_nx;
    logic [0:3] cnt, cnt_nx;
    logic       err_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_error <= 1'b0;
        end else if (err_set) begin
            hazard_error <= 1'b1;
        end
    end

    // mem_wait holds state, counter and timeout tracking; a coincident resolve is dropped.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_set  = 1'b0;
        if (!mem_wait) begin
            case (state)
                RUN: begin
                    if (load_bubble) begin
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_nx = LSTALL;
                            cnt_nx   = LOAD_INIT;
                        end
                    end else if (branch_bubble) begin
                        state_nx = BWAIT;
                        cnt_nx   = '0;
                    end
                end
                LSTALL: begin
                    if (cnt == '0) begin
                        state_nx = RUN;
                    end else begin
                        cnt_nx = cnt - 4'd1;
                    end
                end
                BWAIT: begin
                    if (branch_resolved) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                    end else if (cnt == BWAIT_MAX) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                        err_set  = 1'b1;
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
                default: begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Mealy outputs are gated by rst_n so they read 0 throughout reset.
    always_comb begin
        fetch_stall   = 1'b0;
        decode_bubble = 1'b0;
        pc_redirect   = 1'b0;
        fetch_flush   = 1'b0;
        pipe_freeze   = 1'b0;
        if (!rst_n) begin
            fetch_stall = 1'b0;
        end else if (mem_wait) begin
            pipe_freeze = 1'b1;
            fetch_stall = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (load_bubble || branch_bubble) begin
                        fetch_stall   = 1'b1;
                        decode_bubble = 1'b1;
                    end
                end
                LSTALL: begin
                    fetch_stall   = 1'b1;
                    decode_bubble = 1'b1;
                end
                BWAIT: begin
                    if (branch_resolved) begin
                        if (branch_taken) begin
                            pc_redirect   = 1'b1;
                            fetch_flush   = 1'b1;
                            decode_bubble = 1'b1;
                        end
                    end else if (cnt == BWAIT_MAX) begin
                        fetch_flush = 1'b1;
                    end else begin
                        fetch_stall   = 1'b1;
                        decode_bubble = 1'b1;
                    end
                end
                default: begin
                    fetch_stall = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (fetch_stall && (stall_count != '1)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer; three instances cover LOAD_STALL_CYCLES = 2, 1, 3.
module tb_hazard_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lb = 1'b0, bb = 1'b0, br = 1'b0, bt = 1'b0, mw = 1'b0;

    logic a_fs, a_db, a_pr, a_ff, a_pf, a_he;
    logic b_fs, b_db, b_pr, b_ff, b_pf, b_he;
    logic c_fs, c_db, c_pr, c_ff, c_pf, c_he;
    logic [0:15] a_sc, b_sc, c_sc;
    logic [5:0] a_v, b_v, c_v;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Vector order: fetch_stall, decode_bubble, pc_redirect, fetch_flush, pipe_freeze, hazard_error
    assign a_v = {a_fs, a_db, a_pr, a_ff, a_pf, a_he};
    assign b_v = {b_fs, b_db, b_pr, b_ff, b_pf, b_he};
    assign c_v = {c_fs, c_db, c_pr, c_ff, c_pf, c_he};

    hazard_sequencer #(.LOAD_STALL_CYCLES(2), .BRANCH_WAIT_MAX(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .load_bubble(lb), .branch_bubble(bb),
        .branch_resolved(br), .branch_taken(bt), .mem_wait(mw),
        .fetch_stall(a_fs), .decode_bubble(a_db), .pc_redirect(a_pr), .fetch_flush(a_ff),
        .pipe_freeze(a_pf), .hazard_error(a_he), .stall_count(a_sc));

    hazard_sequencer #(.LOAD_STALL_CYCLES(1), .BRANCH_WAIT_MAX(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load_bubble(lb), .branch_bubble(bb),
        .branch_resolved(br), .branch_taken(bt), .mem_wait(mw),
        .fetch_stall(b_fs), .decode_bubble(b_db), .pc_redirect(b_pr), .fetch_flush(b_ff),
        .pipe_freeze(b_pf), .hazard_error(b_he), .stall_count(b_sc));

    hazard_sequencer #(.LOAD_STALL_CYCLES(3), .BRANCH_WAIT_MAX(3)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .load_bubble(lb), .branch_bubble(bb),
        .branch_resolved(br), .branch_taken(bt), .mem_wait(mw),
        .fetch_stall(c_fs), .decode_bubble(c_db), .pc_redirect(c_pr), .fetch_flush(c_ff),
        .pipe_freeze(c_pf), .hazard_error(c_he), .stall_count(c_sc));

    // Stimulus order: load_bubble, branch_bubble, branch_resolved, branch_taken, mem_wait
    task automatic drive(input logic [4:0] s);
        @(negedge clk);
        {lb, bb, br, bt, mw} = s;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        {lb, bb, br, bt, mw} = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        {lb, bb, br, bt, mw} = 5'b11011;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_v, b_v, c_v} !== 18'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b/%b/%b expected=0", a_v, b_v, c_v);
        end
        n_checks++;
        if ({a_sc, b_sc, c_sc} !== 48'b0) begin
            n_fail++;
            $display("FAIL reset_stall_count got=%0d/%0d/%0d expected=0", a_sc, b_sc, c_sc);
        end
        @(negedge clk);
        {lb, bb, br, bt, mw} = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_load_stall();
        logic [4:0] stim [4] = '{5'b10000, 5'b00000, 5'b00000, 5'b00000};
        logic [5:0] exp_v [4] = '{6'b110000, 6'b110000, 6'b000000, 6'b000000};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            n_checks++;
            if (a_v !== exp_v[i]) begin
                n_fail++;
                $display("FAIL load_stall[%0d] got=%b expected=%b", i, a_v, exp_v[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [4:0] stim [7] = '{5'b01000, 5'b00000, 5'b00110, 5'b00000,
                                 5'b01000, 5'b00100, 5'b00000};
        logic [5:0] exp_v [7] = '{6'b110000, 6'b110000, 6'b011100, 6'b000000,
                                  6'b110000, 6'b000000, 6'b000000};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(stim[i]);
            n_checks++;
            if (a_v !== exp_v[i]) begin
                n_fail++;
                $display("FAIL branch[%0d] got=%b expected=%b", i, a_v, exp_v[i]);
            end
        end
    endtask

    task automatic test_load_priority();
        logic [4:0] stim [6] = '{5'b11000, 5'b00000, 5'b01000, 5'b00000, 5'b00100, 5'b00000};
        logic [5:0] exp_v [6] = '{6'b110000, 6'b000000, 6'b110000, 6'b110000, 6'b000000, 6'b000000};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(stim[i]);
            n_checks++;
            if (b_v !== exp_v[i]) begin
                n_fail++;
                $display("FAIL load_priority[%0d] got=%b expected=%b", i, b_v, exp_v[i]);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [4:0] stim [13] = '{5'b10000, 5'b00001, 5'b00001, 5'b01101, 5'b00001,
                                  5'b00000, 5'b00000, 5'b00000,
                                  5'b01000, 5'b00111, 5'b00000, 5'b00110, 5'b00000};
        logic [5:0] exp_v [13] = '{6'b110000, 6'b100010, 6'b100010, 6'b100010, 6'b100010,
                                   6'b110000, 6'b110000, 6'b000000,
                                   6'b110000, 6'b100010, 6'b110000, 6'b011100, 6'b000000};
        logic [15:0] exp_sc;
        apply_reset();
        for (int i = 0; i < 13; i++) begin
            drive(stim[i]);
            n_checks++;
            if (c_v !== exp_v[i]) begin
                n_fail++;
                $display("FAIL mem_wait[%0d] got=%b expected=%b", i, c_v, exp_v[i]);
            end
        end
`ifdef HAZARD_STATS_EN
        exp_sc = 16'd10;
`else
        exp_sc = 16'd0;
`endif
        n_checks++;
        if (c_sc !== exp_sc) begin
            n_fail++;
            $display("FAIL stall_count got=%0d expected=%0d", c_sc, exp_sc);
        end
    endtask

    task automatic test_resolve_at_timeout();
        logic [4:0] stim [7] = '{5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 5'b00000};
        logic [5:0] exp_v [7] = '{6'b110000, 6'b110000, 6'b110000, 6'b110000,
                                  6'b000000, 6'b000000, 6'b000000};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(stim[i]);
            n_checks++;
            if (a_v !== exp_v[i]) begin
                n_fail++;
                $display("FAIL resolve_at_timeout[%0d] got=%b expected=%b", i, a_v, exp_v[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [4:0] stim [9] = '{5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                                 5'b00000, 5'b10000, 5'b00000, 5'b00000};
        logic [5:0] exp_v [9] = '{6'b110000, 6'b110000, 6'b110000, 6'b110000, 6'b000100,
                                  6'b000001, 6'b110001, 6'b110001, 6'b000001};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive(stim[i]);
            n_checks++;
            if (a_v !== exp_v[i]) begin
                n_fail++;
                $display("FAIL timeout[%0d] got=%b expected=%b", i, a_v, exp_v[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        drive(5'b01000);
        drive(5'b00000);
        n_checks++;
        if (a_v !== 6'b110001) begin
            n_fail++;
            $display("FAIL async_pre got=%b expected=110001", a_v);
        end
        {lb, bb, br, bt, mw} = 5'b01000;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_v, a_sc} !== 22'b0) begin
            n_fail++;
            $display("FAIL async_reset got=%b count=%0d expected=0", a_v, a_sc);
        end
        @(negedge clk);
        {lb, bb, br, bt, mw} = '0;
        rst_n = 1'b1;
        drive(5'b00000);
        n_checks++;
        if (a_v !== 6'b000000) begin
            n_fail++;
            $display("FAIL async_post got=%b expected=000000", a_v);
        end
    endtask

    initial begin
        test_reset();
        test_load_stall();
        test_branch();
        test_load_priority();
        test_mem_wait();
        test_resolve_at_timeout();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
